// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - single-clock FIFO pointer controller
// Wrap-bit pointers, registered occupancy/status flags and sticky error flags.
module fifo_ptr_ctrl #(
  parameter int addr_width      = 4,
  parameter int full_threshold  = 5,
  parameter int empty_threshold = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                err_clr,
  output logic                wr_en,
  output logic                rd_en,
  output logic [addr_width:0] wt_addr,
  output logic [addr_width:0] rd_addr,
  output logic [addr_width:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                push_on_full_error,
  output logic                pop_on_empty_error
);

  localparam logic [addr_width:0] depth = (addr_width + 1)'(1) << addr_width;

  logic                push_acc;
  logic                pop_acc;
  logic                push_rej;
  logic                pop_rej;
  logic [addr_width:0] count_next;
  logic [addr_width:0] free_next;

  // Acceptance uses the registered flags, so a push is never re-evaluated
  // against a pop issued in the same cycle.
  assign push_acc = push & ~full & ~rst;
  assign pop_acc  = pop & ~empty & ~rst;
  assign push_rej = push & full;
  assign pop_rej  = pop & empty;
  assign wr_en    = push_acc;
  assign rd_en    = pop_acc;

  assign count_next = count + {{addr_width{1'b0}}, push_acc} - {{addr_width{1'b0}}, pop_acc};
  assign free_next  = depth - count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      wt_addr            <= '0;
      rd_addr            <= '0;
      count              <= '0;
      full               <= 1'b0;
      empty              <= 1'b1;
      almost_full        <= (int'(depth) <= full_threshold);
      almost_empty       <= 1'b1;
      push_on_full_error <= 1'b0;
      pop_on_empty_error <= 1'b0;
    end else begin
      wt_addr            <= wt_addr + {{addr_width{1'b0}}, push_acc};
      rd_addr            <= rd_addr + {{addr_width{1'b0}}, pop_acc};
      count              <= count_next;
      full               <= (count_next == depth);
      empty              <= (count_next == '0);
      almost_full        <= (int'(free_next) <= full_threshold);
      almost_empty       <= (int'(count_next) <= empty_threshold);
      // A rejection in the same cycle as err_clr keeps the flag set.
      push_on_full_error <= push_rej | (push_on_full_error & ~err_clr);
      pop_on_empty_error <= pop_rej | (pop_on_empty_error & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - scoreboard bench for fifo_ptr_ctrl
// Driver pushes model expectations into a queue; a monitor pops and compares.
module tb_fifo_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MOD   = 32;
  localparam int FT    = 5;
  localparam int ET    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          err_clr = 1'b0;
  logic          wr_en, rd_en;
  logic [AW:0]   wt_addr, rd_addr, count;
  logic          full, empty, almost_full, almost_empty;
  logic          push_on_full_error, pop_on_empty_error;

  fifo_ptr_ctrl #(.addr_width(AW), .full_threshold(FT), .empty_threshold(ET)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .err_clr(err_clr),
    .wr_en(wr_en), .rd_en(rd_en), .wt_addr(wt_addr), .rd_addr(rd_addr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .push_on_full_error(push_on_full_error),
    .pop_on_empty_error(pop_on_empty_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wr; int rd;
    int wt; int ra; int cnt;
    int fl; int em; int af; int ae; int pe; int ee;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: total accepted pushes/pops since reset.
  int n_push = 0, n_pop = 0;
  int m_pe = 0, m_ee = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic step(input bit p, input bit q, input bit c, input bit r);
    exp_t e;
    int   cnt;
    bit   pa, qa;
    @(posedge clk);
    #2;
    push = p; pop = q; err_clr = c; rst = r;
    if (r) begin
      e.wr = 0; e.rd = 0;
      n_push = 0; n_pop = 0; m_pe = 0; m_ee = 0;
    end else begin
      cnt = n_push - n_pop;
      pa = p && (cnt < DEPTH);
      qa = q && (cnt > 0);
      e.wr = pa; e.rd = qa;
      m_pe = (p && !pa) || (m_pe && !c);
      m_ee = (q && !qa) || (m_ee && !c);
      n_push += pa; n_pop += qa;
    end
    cnt   = n_push - n_pop;
    e.wt  = n_push % MOD;
    e.ra  = n_pop % MOD;
    e.cnt = cnt;
    e.fl  = (cnt == DEPTH);
    e.em  = (cnt == 0);
    e.af  = ((DEPTH - cnt) <= FT);
    e.ae  = (cnt <= ET);
    e.pe  = m_pe;
    e.ee  = m_ee;
    exp_q.push_back(e);
  endtask

  // Monitor: strobes mid-cycle, registered state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("wr_en", int'(wr_en), e.wr);
        check("rd_en", int'(rd_en), e.rd);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("wt_addr", int'(wt_addr), e.wt);
        check("rd_addr", int'(rd_addr), e.ra);
        check("count", int'(count), e.cnt);
        check("full", int'(full), e.fl);
        check("empty", int'(empty), e.em);
        check("almost_full", int'(almost_full), e.af);
        check("almost_empty", int'(almost_empty), e.ae);
        check("push_on_full_error", int'(push_on_full_error), e.pe);
        check("pop_on_empty_error", int'(pop_on_empty_error), e.ee);
      end
    end
  end

  initial begin
    int bias;
    // Reset held with push/pop asserted
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    // Fill to full
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0);
    // Push on full, clear collision, clean clear
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    // Pop on empty, then push+pop on empty
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    // Preload to 3, then long wrap with push+pop
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    // Fill, push+pop at full, drain to 7, reset mid-operation
    for (int i = 0; i < 13; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // Randomized phases with shifting push/pop bias
    for (int i = 0; i < 800; i++) begin
      bias = ((i / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(99, 0) < bias, $urandom_range(99, 0) < (100 - bias),
           $urandom_range(15, 0) == 0, $urandom_range(199, 0) == 0);
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
